// File: rtl/sp_core.sv
// Single-cycle core: decodes the instruction presented with in_valid, commits the
// register write and PC update at the same edge, and drives the async-read data memory.
module sp_core #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int MEM_AW  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       inst,
    output logic              out_valid,
    output logic [31:0]       inst_addr,
    output logic              mem_wen,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int RA_W = $clog2(REG_NUM);

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_ANDI = 6'd1;
    localparam logic [5:0] OP_ORI  = 6'd2;
    localparam logic [5:0] OP_ADDI = 6'd3;
    localparam logic [5:0] OP_SUBI = 6'd4;
    localparam logic [5:0] OP_LW   = 6'd5;
    localparam logic [5:0] OP_SW   = 6'd6;
    localparam logic [5:0] OP_BEQ  = 6'd7;
    localparam logic [5:0] OP_BNE  = 6'd8;
    localparam logic [5:0] OP_LUI  = 6'd9;
    localparam logic [5:0] OP_J    = 6'd10;
    localparam logic [5:0] OP_JAL  = 6'd11;

    logic [DATA_W-1:0] r_regs [0:REG_NUM-1];
    logic [31:0]       r_pc;
    logic              r_out_valid;

    logic [5:0]        w_op;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [4:0]        w_sh;
    logic [5:0]        w_fn;
    logic [15:0]       w_imm;
    logic [25:0]       w_jaddr;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_simm;
    logic [DATA_W-1:0] w_zimm;
    logic [31:0]       w_pc_plus4;
    logic [31:0]       w_pc_jump;
    logic [31:0]       w_pc_branch;
    logic              w_lt;
    logic              w_wen;
    logic [RA_W-1:0]   w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [31:0]       w_pc_next;

    assign w_op    = inst[31:26];
    assign w_rs    = inst[25:21];
    assign w_rt    = inst[20:16];
    assign w_rd    = inst[15:11];
    assign w_sh    = inst[10:6];
    assign w_fn    = inst[5:0];
    assign w_imm   = inst[15:0];
    assign w_jaddr = inst[25:0];

    // Operands come from pre-commit state, so rd == rs reads the old value.
    assign w_a    = r_regs[w_rs];
    assign w_b    = r_regs[w_rt];
    assign w_simm = {{(DATA_W-16){w_imm[15]}}, w_imm};
    assign w_zimm = {{(DATA_W-16){1'b0}}, w_imm};
    assign w_lt   = $signed(w_a) < $signed(w_b);

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_pc_jump   = {r_pc[31:28], w_jaddr, 2'b00};
    assign w_pc_branch = w_pc_plus4 + {w_simm[29:0], 2'b00};

    // Only the low address bits reach memory, so only those are summed.
    assign mem_addr  = w_a[MEM_AW-1:0] + w_simm[MEM_AW-1:0];
    assign mem_wdata = w_b;
    assign mem_wen   = in_valid && (w_op == OP_SW);

    always_comb begin
        w_wen     = 1'b0;
        w_waddr   = w_rt;
        w_wdata   = '0;
        w_pc_next = w_pc_plus4;
        case (w_op)
            OP_R: begin
                w_waddr = w_rd;
                case (w_fn)
                    6'd0: begin w_wen = 1'b1; w_wdata = w_a & w_b;    end
                    6'd1: begin w_wen = 1'b1; w_wdata = w_a | w_b;    end
                    6'd2: begin w_wen = 1'b1; w_wdata = w_a + w_b;    end
                    6'd3: begin w_wen = 1'b1; w_wdata = w_a - w_b;    end
                    6'd4: begin w_wen = 1'b1; w_wdata = {{(DATA_W-1){1'b0}}, w_lt}; end
                    6'd5: begin w_wen = 1'b1; w_wdata = w_a << w_sh;  end
                    6'd6: begin w_wen = 1'b1; w_wdata = ~(w_a | w_b); end
                    6'd7: w_pc_next = r_regs[31];
                    default: ;
                endcase
            end
            OP_ANDI: begin w_wen = 1'b1; w_wdata = w_a & w_zimm; end
            OP_ORI:  begin w_wen = 1'b1; w_wdata = w_a | w_zimm; end
            OP_ADDI: begin w_wen = 1'b1; w_wdata = w_a + w_simm; end
            OP_SUBI: begin w_wen = 1'b1; w_wdata = w_a - w_simm; end
            OP_LW:   begin w_wen = 1'b1; w_wdata = mem_rdata;    end
            OP_BEQ:  if (w_a == w_b) w_pc_next = w_pc_branch;
            OP_BNE:  if (w_a != w_b) w_pc_next = w_pc_branch;
            OP_LUI:  begin w_wen = 1'b1; w_wdata = {w_imm, 16'h0000}; end
            OP_J:    w_pc_next = w_pc_jump;
            OP_JAL: begin
                w_wen     = 1'b1;
                w_waddr   = 5'd31;
                w_wdata   = w_pc_plus4;
                w_pc_next = w_pc_jump;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_pc <= w_pc_next;
                if (w_wen) begin
                    r_regs[w_waddr] <= w_wdata;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign inst_addr = r_pc;

endmodule

// File: tb/tb_sp_core.sv
// Scoreboard bench for sp_core: a reference model predicts each commit, a monitor
// checks PC, destination register and store target whenever out_valid is seen.
module tb_sp_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inst = '0;
    logic        out_valid;
    logic [31:0] inst_addr;
    logic        mem_wen;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    sp_core #(.DATA_W(32), .REG_NUM(32), .MEM_AW(12)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inst(inst),
        .out_valid(out_valid), .inst_addr(inst_addr), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // External data memory: async read, write at posedge.
    logic [31:0] mem [0:4095];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_wdata;

    typedef struct {
        logic [31:0] pc;
        logic        wr;
        logic [4:0]  idx;
        logic [31:0] val;
        logic        st;
        logic [11:0] saddr;
        logic [31:0] sval;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference architectural state
    logic [31:0] m_r [0:31];
    logic [31:0] m_mem [0:4095];
    logic [31:0] m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] a);
        return {op, a};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_r[i] = '0;
        m_pc = '0;
    endtask

    task automatic issue(input logic [31:0] ins);
        exp_t e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a, b, simm, zimm, np, ea;
        op   = ins[31:26];
        fn   = ins[5:0];
        a    = m_r[ins[25:21]];
        b    = m_r[ins[20:16]];
        simm = 32'($signed(ins[15:0]));
        zimm = {16'h0, ins[15:0]};
        ea   = a + simm;
        np   = m_pc + 4;
        e.wr = 1'b0; e.idx = ins[20:16]; e.val = '0;
        e.st = 1'b0; e.saddr = ea[11:0]; e.sval = b;
        chk("fetch_pc", inst_addr, m_pc);
        case (op)
            6'd0: begin
                e.idx = ins[15:11];
                e.wr  = (fn <= 6);
                case (fn)
                    6'd0: e.val = a & b;
                    6'd1: e.val = a | b;
                    6'd2: e.val = a + b;
                    6'd3: e.val = a - b;
                    6'd4: e.val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'd5: e.val = a << ins[10:6];
                    6'd6: e.val = ~(a | b);
                    6'd7: np = m_r[31];
                    default: ;
                endcase
            end
            6'd1: begin e.wr = 1; e.val = a & zimm; end
            6'd2: begin e.wr = 1; e.val = a | zimm; end
            6'd3: begin e.wr = 1; e.val = a + simm; end
            6'd4: begin e.wr = 1; e.val = a - simm; end
            6'd5: begin e.wr = 1; e.val = m_mem[ea[11:0]]; end
            6'd6: e.st = 1;
            6'd7: if (a == b) np = m_pc + 4 + (simm << 2);
            6'd8: if (a != b) np = m_pc + 4 + (simm << 2);
            6'd9: begin e.wr = 1; e.val = {ins[15:0], 16'h0}; end
            6'd10: np = {m_pc[31:28], ins[25:0], 2'b00};
            6'd11: begin
                e.wr = 1; e.idx = 5'd31; e.val = m_pc + 4;
                np = {m_pc[31:28], ins[25:0], 2'b00};
            end
            default: ;
        endcase
        if (e.st) m_mem[e.saddr] = e.sval;
        if (e.wr) m_r[e.idx] = e.val;
        m_pc = np;
        e.pc = np;
        q.push_back(e);
        in_valid = 1'b1;
        inst = ins;
        #1;
        chk("mem_wen", {31'd0, mem_wen}, {31'd0, op == 6'd6});
        @(posedge clk);
        @(negedge clk);
        chk("out_valid_hi", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic idle(input int n);
        int nmis;
        in_valid = 1'b0;
        inst = enc_i(6'd6, 5'd1, 5'd1, 16'($urandom));
        #1;
        chk("mem_wen_idle", {31'd0, mem_wen}, 32'd0);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            chk("out_valid_lo", {31'd0, out_valid}, 32'd0);
            chk("pc_hold", inst_addr, m_pc);
            nmis = 0;
            for (int i = 0; i < 32; i++) if (dut.r_regs[i] !== m_r[i]) nmis++;
            chk("regs_hold_mismatches", nmis, 0);
        end
    endtask

    task automatic do_reset();
        int nz;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_inst_addr", inst_addr, 32'd0);
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.r_regs[i] !== 32'd0) nz++;
        chk("rst_regs_nonzero", nz, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] op;
        logic [5:0] fn;
        op = 6'($urandom_range(0, 13));
        if (op == 6'd0) begin
            fn = 6'($urandom_range(0, 9));
            if (fn == 6'd7 && m_r[31][1:0] != 2'b00) fn = 6'd2;
            return enc_r(rreg(), rreg(), rreg(), 5'($urandom), fn);
        end
        if (op == 6'd10 || op == 6'd11) return enc_j(op, 26'($urandom));
        return enc_i(op, rreg(), rreg(), 16'($urandom));
    endfunction

    // Monitor: one scoreboard entry per observed commit.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_commit: out_valid=1 with no instruction outstanding (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    $display("commit pc_next=0x%08h wr=%0d r%0d=0x%08h st=%0d", e.pc, e.wr, e.idx, e.val, e.st);
                    chk("commit_pc", inst_addr, e.pc);
                    if (e.wr) chk("commit_reg", dut.r_regs[e.idx], e.val);
                    if (e.st) chk("commit_store", mem[e.saddr], e.sval);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = '0;
            m_mem[i] = '0;
        end
        model_reset();
        @(negedge clk);
        do_reset();

        issue(enc_i(6'd3, 5'd0, 5'd1, 16'd5));
        issue(enc_i(6'd3, 5'd0, 5'd2, 16'hFFFD));
        issue(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'd2));
        issue(enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'd4));
        chk("add_r3", dut.r_regs[3], 32'd2);
        chk("slt_r4", dut.r_regs[4], 32'd1);
        chk("pc_after4", inst_addr, 32'd16);

        issue(enc_i(6'd6, 5'd0, 5'd1, 16'd100));
        issue(enc_i(6'd5, 5'd0, 5'd5, 16'd100));
        chk("sw_mem100", mem[100], 32'd5);
        chk("lw_r5", dut.r_regs[5], 32'd5);

        issue(enc_j(6'd10, 26'h4));
        chk("j_0x10", inst_addr, 32'h10);
        issue(enc_i(6'd7, 5'd1, 5'd1, 16'd2));
        chk("beq_taken", inst_addr, 32'h1C);
        issue(enc_i(6'd8, 5'd1, 5'd1, 16'd2));
        chk("bne_not_taken", inst_addr, 32'h20);
        issue(enc_j(6'd11, 26'h40));
        chk("jal_r31", dut.r_regs[31], 32'h24);
        chk("jal_pc", inst_addr, 32'h100);
        issue(enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'd7));
        chk("jr_pc", inst_addr, 32'h24);

        issue(enc_r(5'd1, 5'd1, 5'd1, 5'd0, 6'd2));
        chk("self_double", dut.r_regs[1], 32'd10);
        idle(2);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
            issue(rand_inst());
        end
        idle(1);

        do_reset();
        issue(enc_i(6'd3, 5'd0, 5'd6, 16'd7));
        chk("post_reset_r6", dut.r_regs[6], 32'd7);
        chk("post_reset_pc", inst_addr, 32'd4);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
            issue(rand_inst());
        end
        idle(2);
        chk("scoreboard_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
